// File: rtl/activation_writeout_pkg.sv
// -----------------------------------------------------------------------------
// activation_writeout_pkg
//   Shared definitions for the activation write-back slice: build-time size
//   macros (used as parameter defaults), the write-out FSM state encoding,
//   the row-counter width default and lane-slice width constants.
//
//   Macros (overridable on the command line):
//     MAT_MUL_SIZE  lanes per vector          (default 4)
//     DWIDTH        bits per lane             (default 8)
//     AWIDTH        output BRAM address width (default 8)
//     MASK_WIDTH    mask bits, one per lane   (default MAT_MUL_SIZE)
// -----------------------------------------------------------------------------
`ifndef MAT_MUL_SIZE
`define MAT_MUL_SIZE 4
`endif
`ifndef DWIDTH
`define DWIDTH 8
`endif
`ifndef AWIDTH
`define AWIDTH 8
`endif
`ifndef MASK_WIDTH
`define MASK_WIDTH `MAT_MUL_SIZE
`endif

package activation_writeout_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } wo_state_e;

  localparam int CNT_W_DEF  = 8;
  localparam int LANES_DEF  = `MAT_MUL_SIZE;
  localparam int LANE_W_DEF = `DWIDTH;
  localparam int ROW_W_DEF  = `MAT_MUL_SIZE * `DWIDTH;

endpackage

// File: rtl/activation_writeout_if.sv
// -----------------------------------------------------------------------------
// activation_writeout_if
//   Groups the activation vector stream (valid, data, lane mask) with the
//   output-matrix BRAM write port it is turned into.
//     master : drives the vector stream, observes the BRAM write port
//     slave  : the write-out stage; consumes the stream, drives the BRAM port
// -----------------------------------------------------------------------------
interface activation_writeout_if #(
  parameter int MAT_MUL_SIZE = `MAT_MUL_SIZE,
  parameter int DWIDTH       = `DWIDTH,
  parameter int AWIDTH       = `AWIDTH,
  parameter int MASK_WIDTH   = `MASK_WIDTH
);
  import activation_writeout_pkg::*;

  logic                           in_data_available;
  logic [MAT_MUL_SIZE*DWIDTH-1:0] inp_data;
  logic [MASK_WIDTH-1:0]          validity_mask;

  logic [AWIDTH-1:0]              bram_addr;
  logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_wdata;
  logic [MASK_WIDTH-1:0]          bram_we;

  modport master (
    output in_data_available, inp_data, validity_mask,
    input  bram_addr, bram_wdata, bram_we
  );

  modport slave (
    input  in_data_available, inp_data, validity_mask,
    output bram_addr, bram_wdata, bram_we
  );

endinterface

// File: rtl/writeout_addr_gen.sv
// -----------------------------------------------------------------------------
// writeout_addr_gen
//   Row address / row count generator for the write-out window.
//     clk, reset  clock, asynchronous active-high reset
//     load        capture stride and row count, address := base, count := 0
//     step        a row is accepted: address += stride, count += 1
//     base        first row address (used on load)
//     stride      per-row address increment (captured on load)
//     num_rows    rows in the window (captured on load)
//     addr        address for the row being accepted this cycle
//     last_row    the row accepted this cycle is the final one
// -----------------------------------------------------------------------------
module writeout_addr_gen
  import activation_writeout_pkg::*;
#(
  parameter int AWIDTH = `AWIDTH,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [AWIDTH-1:0] base,
  input  logic [AWIDTH-1:0] stride,
  input  logic [CNT_W-1:0]  num_rows,
  output logic [AWIDTH-1:0] addr,
  output logic              last_row
);

  logic [AWIDTH-1:0] stride_q;
  logic [AWIDTH-1:0] addr_q;
  logic [CNT_W-1:0]  num_rows_q;
  logic [CNT_W-1:0]  row_cnt_q;
  logic [CNT_W-1:0]  row_cnt_nxt;

  assign row_cnt_nxt = row_cnt_q + 1'b1;
  assign addr        = addr_q;
  assign last_row    = (row_cnt_nxt == num_rows_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stride_q   <= '0;
      addr_q     <= '0;
      num_rows_q <= '0;
      row_cnt_q  <= '0;
    end else if (load) begin
      stride_q   <= stride;
      addr_q     <= base;
      num_rows_q <= num_rows;
      row_cnt_q  <= '0;
    end else if (step) begin
      // Address wraps silently modulo 2^AWIDTH.
      addr_q     <= addr_q + stride_q;
      row_cnt_q  <= row_cnt_nxt;
    end
  end

endmodule

// File: rtl/activation_writeout.sv
// -----------------------------------------------------------------------------
// activation_writeout
//   Write-back stage: takes valid-qualified MAT_MUL_SIZE-lane vectors from the
//   activation block and writes them row by row into the output BRAM starting
//   at a programmable base address with a programmable stride. Raises
//   done_writeout after num_rows rows, and a sticky extra_data_err when valid
//   data arrives while no write-out window is active.
//
//   Ports:
//     clk, reset        clock, asynchronous active-high reset
//     enable_writeout   level; opens (and holds open) a write-out window
//     address_base      first row address, sampled on window start
//     address_stride    per-row address increment, sampled on window start
//     num_rows          rows to write, sampled on window start
//     wo (slave)        in_data_available / inp_data / validity_mask in,
//                       bram_addr / bram_wdata / bram_we out (1-cycle latency)
//     done_writeout     window complete, held until enable_writeout drops
//     extra_data_err    sticky, cleared only by reset
//
//   Build option WRITEOUT_ZERO_MASK_EN: masked-off lanes are written as zero
//   and every accepted row is a full-row write (bram_we all ones). Without it
//   data passes unmodified and bram_we follows validity_mask.
// -----------------------------------------------------------------------------
module activation_writeout
  import activation_writeout_pkg::*;
#(
  parameter int MAT_MUL_SIZE = `MAT_MUL_SIZE,
  parameter int DWIDTH       = `DWIDTH,
  parameter int AWIDTH       = `AWIDTH,
  parameter int MASK_WIDTH   = `MASK_WIDTH,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_writeout,
  input  logic [AWIDTH-1:0] address_base,
  input  logic [AWIDTH-1:0] address_stride,
  input  logic [CNT_W-1:0]  num_rows,
  activation_writeout_if.slave wo,
  output logic              done_writeout,
  output logic              extra_data_err
);

  localparam int ROW_W = MAT_MUL_SIZE * DWIDTH;

  wo_state_e         state;
  logic [AWIDTH-1:0] cur_addr;
  logic              last_row;
  logic              load;
  logic              step;
  logic [ROW_W-1:0]      row_wdata;
  logic [MASK_WIDTH-1:0] row_we;

  logic [AWIDTH-1:0]     bram_addr_p1;
  logic [ROW_W-1:0]      bram_wdata_p1;
  logic [MASK_WIDTH-1:0] bram_we_p1;

`ifdef WRITEOUT_ZERO_MASK_EN
  function automatic logic [ROW_W-1:0] zero_masked_lanes(
    input logic [ROW_W-1:0]      data,
    input logic [MASK_WIDTH-1:0] mask
  );
    logic [ROW_W-1:0] res;
    res = data;
    for (int i = 0; i < MAT_MUL_SIZE; i++) begin
      if (!mask[i]) res[i*DWIDTH +: DWIDTH] = '0;
    end
    return res;
  endfunction

  assign row_wdata = zero_masked_lanes(wo.inp_data, wo.validity_mask);
  assign row_we    = '1;
`else
  assign row_wdata = wo.inp_data;
  assign row_we    = wo.validity_mask;
`endif

  // Window start loads the generator; a row is only accepted while the
  // window is still enabled (dropping enable takes priority over data).
  assign load = (state == IDLE)   && enable_writeout;
  assign step = (state == ACTIVE) && enable_writeout && wo.in_data_available;

  writeout_addr_gen #(
    .AWIDTH (AWIDTH),
    .CNT_W  (CNT_W)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .step     (step),
    .base     (address_base),
    .stride   (address_stride),
    .num_rows (num_rows),
    .addr     (cur_addr),
    .last_row (last_row)
  );

  // ---- stage p1: registered BRAM write and FSM outputs ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      bram_addr_p1   <= '0;
      bram_wdata_p1  <= '0;
      bram_we_p1     <= '0;
      done_writeout  <= 1'b0;
      extra_data_err <= 1'b0;
    end else begin
      bram_we_p1 <= '0;
      case (state)
        IDLE: begin
          if (wo.in_data_available) extra_data_err <= 1'b1;
          if (enable_writeout) begin
            if (num_rows == '0) begin
              state         <= DONE;
              done_writeout <= 1'b1;
            end else begin
              state <= ACTIVE;
            end
          end
        end
        ACTIVE: begin
          if (!enable_writeout) begin
            state <= IDLE;
          end else if (wo.in_data_available) begin
            bram_addr_p1  <= cur_addr;
            bram_wdata_p1 <= row_wdata;
            bram_we_p1    <= row_we;
            if (last_row) begin
              state         <= DONE;
              done_writeout <= 1'b1;
            end
          end
        end
        DONE: begin
          if (wo.in_data_available) extra_data_err <= 1'b1;
          if (!enable_writeout) begin
            state         <= IDLE;
            done_writeout <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          done_writeout <= 1'b0;
        end
      endcase
    end
  end

  assign wo.bram_addr  = bram_addr_p1;
  assign wo.bram_wdata = bram_wdata_p1;
  assign wo.bram_we    = bram_we_p1;

endmodule

// File: tb/tb_activation_writeout.sv
// -----------------------------------------------------------------------------
// tb_activation_writeout
//   Scoreboard bench for activation_writeout: every driven cycle pushes the
//   expected BRAM port / done state for the following edge; a monitor pops
//   and compares one entry per clock.
// -----------------------------------------------------------------------------
module tb_activation_writeout;
  import activation_writeout_pkg::*;

  localparam int L  = LANES_DEF;
  localparam int DW = LANE_W_DEF;
  localparam int W  = ROW_W_DEF;
  localparam int AW = `AWIDTH;
  localparam int MW = `MASK_WIDTH;
  localparam int CW = CNT_W_DEF;

  typedef struct {
    logic          wr;
    logic [MW-1:0] we;
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata;
    logic          done;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          enable_writeout;
  logic [AW-1:0] address_base;
  logic [AW-1:0] address_stride;
  logic [CW-1:0] num_rows;
  logic          done_writeout;
  logic          extra_data_err;

  int n_vec;
  int n_err;
  exp_t sb[$];
  exp_t mon_e;

  activation_writeout_if #(
    .MAT_MUL_SIZE (L),
    .DWIDTH       (DW),
    .AWIDTH       (AW),
    .MASK_WIDTH   (MW)
  ) io ();

  activation_writeout dut (
    .clk             (clk),
    .reset           (reset),
    .enable_writeout (enable_writeout),
    .address_base    (address_base),
    .address_stride  (address_stride),
    .num_rows        (num_rows),
    .wo              (io.slave),
    .done_writeout   (done_writeout),
    .extra_data_err  (extra_data_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

`ifdef WRITEOUT_ZERO_MASK_EN
  function automatic logic [W-1:0] zero_lanes(input logic [W-1:0] d, input logic [MW-1:0] m);
    logic [W-1:0] keep;
    for (int b = 0; b < W; b++) keep[b] = m[b / DW];
    return d & keep;
  endfunction
`endif

  // Drive one cycle of stimulus and record what the DUT must show after the
  // following rising edge.
  task automatic tick(input logic en, input logic dv, input logic [W-1:0] data,
                      input logic [MW-1:0] mask, input logic wr,
                      input logic [AW-1:0] addr, input logic done);
    exp_t e;
    @(negedge clk);
    enable_writeout      = en;
    io.in_data_available = dv;
    io.inp_data          = data;
    io.validity_mask     = mask;
    e.wr   = wr;
    e.addr = addr;
    e.done = done;
`ifdef WRITEOUT_ZERO_MASK_EN
    e.wdata = zero_lanes(data, mask);
    e.we    = wr ? '1 : '0;
`else
    e.wdata = data;
    e.we    = wr ? mask : '0;
`endif
    sb.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic cfg(input logic [AW-1:0] b, input logic [AW-1:0] s, input logic [CW-1:0] n);
    address_base   = b;
    address_stride = s;
    num_rows       = n;
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      check("bram_we", 64'(io.bram_we), 64'(mon_e.we));
      if (mon_e.wr) begin
        check("bram_addr", 64'(io.bram_addr), 64'(mon_e.addr));
        check("bram_wdata", 64'(io.bram_wdata), 64'(mon_e.wdata));
      end
      check("done_writeout", 64'(done_writeout), 64'(mon_e.done));
    end
  end

  initial begin
    logic [W-1:0] d;
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    enable_writeout      = 1'b0;
    io.in_data_available = 1'b0;
    io.inp_data          = '0;
    io.validity_mask     = '0;
    cfg('0, '0, '0);
    #1 reset = 1'b1;
    #3;
    check("rst_addr",  64'(io.bram_addr),  64'd0);
    check("rst_wdata", 64'(io.bram_wdata), 64'd0);
    check("rst_we",    64'(io.bram_we),    64'd0);
    check("rst_done",  64'(done_writeout), 64'd0);
    check("rst_err",   64'(extra_data_err), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Back-to-back rows, unit stride.
    cfg(8'h10, 8'h01, 8'd4);
    tick(1, 0, '0, '0, 0, '0, 0);
    for (int i = 0; i < 4; i++) begin
      d = W'($urandom);
      tick(1, 1, d, '1, 1, AW'(8'h10 + i), (i == 3));
    end
    tick(1, 0, '0, '0, 0, '0, 1);
    tick(0, 0, '0, '0, 0, '0, 0);

    // Stride 8 with two idle cycles between rows.
    cfg(8'h00, 8'h08, 8'd3);
    tick(1, 0, '0, '0, 0, '0, 0);
    for (int i = 0; i < 3; i++) begin
      d = W'($urandom);
      tick(1, 1, d, '1, 1, AW'(8 * i), (i == 2));
      tick(1, 0, '0, '0, 0, '0, (i == 2));
      tick(1, 0, '0, '0, 0, '0, (i == 2));
    end
    tick(0, 0, '0, '0, 0, '0, 0);

    // Partial lane mask.
    cfg(8'h20, 8'h01, 8'd1);
    tick(1, 0, '0, '0, 0, '0, 0);
    d = W'(32'hA1B2C3D4);
    tick(1, 1, d, MW'(4'b0101), 1, AW'(8'h20), 1);
    tick(0, 0, '0, '0, 0, '0, 0);
    settle();
    check("err_clean", 64'(extra_data_err), 64'd0);

    // Zero rows: immediate done, data then counts as extra.
    cfg(8'h33, 8'h01, 8'd0);
    tick(1, 0, '0, '0, 0, '0, 1);
    tick(1, 1, W'($urandom), '1, 0, '0, 1);
    settle();
    check("err_zero_rows", 64'(extra_data_err), 64'd1);
    tick(0, 0, '0, '0, 0, '0, 0);

    // Address wrap at the top of the address space.
    cfg(AW'((1 << AW) - 1), 8'h02, 8'd2);
    tick(1, 0, '0, '0, 0, '0, 0);
    tick(1, 1, W'($urandom), '1, 1, AW'((1 << AW) - 1), 0);
    tick(1, 1, W'($urandom), '1, 1, AW'(1), 1);
    tick(0, 0, '0, '0, 0, '0, 0);
    settle();

    // Reset after two of five rows, then a fresh window.
    cfg(8'h40, 8'h04, 8'd5);
    tick(1, 0, '0, '0, 0, '0, 0);
    tick(1, 1, W'($urandom), '1, 1, AW'(8'h40), 0);
    tick(1, 1, W'($urandom), '1, 1, AW'(8'h44), 0);
    settle();
    @(negedge clk);
    io.in_data_available = 1'b1;
    reset = 1'b1;
    #1;
    check("mid_rst_we",    64'(io.bram_we),    64'd0);
    check("mid_rst_addr",  64'(io.bram_addr),  64'd0);
    check("mid_rst_wdata", 64'(io.bram_wdata), 64'd0);
    check("mid_rst_done",  64'(done_writeout), 64'd0);
    check("mid_rst_err",   64'(extra_data_err), 64'd0);
    @(negedge clk);
    io.in_data_available = 1'b0;
    enable_writeout = 1'b0;
    reset = 1'b0;
    cfg(8'h80, 8'h01, 8'd2);
    tick(1, 0, '0, '0, 0, '0, 0);
    tick(1, 1, W'($urandom), '1, 1, AW'(8'h80), 0);
    tick(1, 1, W'($urandom), '1, 1, AW'(8'h81), 1);
    tick(0, 0, '0, '0, 0, '0, 0);

    // Window abandoned mid-way: no done.
    cfg(8'h30, 8'h01, 8'd3);
    tick(1, 0, '0, '0, 0, '0, 0);
    tick(1, 1, W'($urandom), '1, 1, AW'(8'h30), 0);
    tick(0, 0, '0, '0, 0, '0, 0);
    tick(0, 0, '0, '0, 0, '0, 0);
    settle();
    check("err_final", 64'(extra_data_err), 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
